sca_stim_engine: RTL
====================

// Module: sca_stim_engine
// PURPOSE
//  Parametrised successor of the SCA unlock harness. Drives the NUM_INS inputs of a locked DUT and captures its NUM_OUTS outputs.
//  Drive modes: static, external flip, timed internal toggle, continuous toggle. All control logic is in the clk domain.
//  One bit-banged serial port (sclk/sdi/sdo) loads the configuration and reads back captured outputs. Sits between board pins and the DUT.
// PARAMETERS
//  NUM_INS   46  DUT input width
//  NUM_OUTS  7   DUT output width
//  CNT_W     16  period / capture counter width
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         reset, asynchronous, active-low
//  sclk       in   1         async serial clock; falling edges shift
//  sdi        in   1         async serial data in
//  shift_en   in   1         async; 0 = shift config chain, 1 = shift output chain
//  start_req  in   1         async; rising edge = start run (or stop, see below)
//  flip_in    in   1         async flip source; combinational path to dut_in in mode 1
//  dut_out    in   NUM_OUTS  DUT outputs
//  dut_in     out  NUM_INS   DUT inputs
//  sdo        out  1         serial out: shift_en ? outr[NUM_OUTS-1] : cfg[CFG_W-1]
//  trig       out  1         scope trigger: high while phase=1 (see RUN)
//  busy       out  1         FSM not IDLE
//  done       out  1         1-cycle pulse per capture
//  cap_cnt    out  CNT_W     captures since last start
// BEHAVIOUR
//  - Synchronisers: sclk, sdi, shift_en and start_req each pass a 2-FF synchroniser, then a registered edge detect.
//    An action fires on the first clk edge at which the 2nd sync stage differs from its previous value (<=3 clk after the pin edge).
//  - Config chain: cfg is CFG_W = 2*NUM_INS+2+CNT_W bits, field layout {value, mask, mode[1:0], period}.
//    Shifted MSB-first: cfg <= {cfg[CFG_W-2:0], sdi_s} on each sclk fall while shift_en_s = 0. Shifting is allowed in any state.
//  - Output chain: outr is NUM_OUTS bits.
//    On an sclk fall with shift_en_s = 1: outr <= {outr[NUM_OUTS-2:0], 1'b0}.
//    A capture in the same cycle wins; that shift is dropped.
//  - start_req rise in IDLE: copy cfg into the active registers (a_val, a_mask, a_mode, a_per); cap_cnt <= 0; phase <= 0; cnt <= 0; go to RUN.
//  - RUN: cnt increments each cycle. At cnt == a_per the FSM captures: outr <= dut_out, done = 1, cap_cnt++, cnt <= 0.
//    Capture period is therefore a_per+1 cycles. a_per = 0 means capture every cycle.
//    Mode 0 (static):  phase = 0 for the whole run; after capture go to IDLE.
//    Mode 1 (ext flip): phase = 0; after capture go to IDLE.
//    Mode 2 (single toggle): phase = 1 from the RUN entry edge until capture; phase <= 0 at the capture edge; go to IDLE.
//    Mode 3 (continuous): phase = 1 on RUN entry; phase toggles at each capture edge; stays in RUN.
//      A start_req rise in RUN sets stop_pend. The next capture then returns to IDLE with phase <= 0.
//  - start_req rise in RUN for modes 0-2 is ignored.
//  - dut_in per bit i:
//    IDLE: a_val[i].
//    RUN, mode 1: a_mask[i] ? flip_in : a_val[i]. This path is combinational, flip_in is not synchronised.
//    RUN, other modes: a_val[i] ^ (a_mask[i] & phase).
//    Active registers hold after a run, so dut_in stays a_val in IDLE.
//  - trig = phase & busy. busy = (state == RUN).
//  - cap_cnt wraps at 2^CNT_W; a wrap does not stop the run.
//  - Reset, including mid-run: state=IDLE, cfg/outr/active regs/cnt/cap_cnt/phase/stop_pend = 0.
//    Outputs: dut_in = 0, sdo = 0, trig = 0, busy = 0, done = 0.
// TESTING
//  1 Hold rst_n low, then release -> dut_in = 0, sdo = 0, busy = 0, cap_cnt = 0. Shift 1 config bit; 3 clk later sdo = 0, then the bit reaches cfg[0].
//  2 Load value = 46'h1, mask = 0, mode = 0, period = 3; start; dut_out = 7'h55 ->
//    busy high exactly 4 clk, done pulses once, cap_cnt = 1; read 7 bits (shift_en = 1) -> 1010101.
//  3 Mode 2, value = 0, mask = 46'h3, period = 9 ->
//    dut_in = 3 and trig = 1 for exactly 10 clk, then dut_in = 0; one done pulse.
//  4 Mode 1, mask = 46'h1, value = 0; toggle flip_in during RUN -> dut_in[0] follows flip_in combinationally, all other bits stay 0.
//  5 Mode 3, period = 1 -> phase/trig alternates every 2 clk.
//    A start_req rise mid-run -> IDLE after the next capture; cap_cnt matches the done count.
//  6 Assert rst_n mid-run (mode 3) -> same cycle busy = 0, dut_in = 0, trig = 0.
//    Capture coinciding with an sclk fall while shift_en = 1 -> outr = dut_out, no shift.

Source files
------------

// File: rtl/sca_stim_engine_if.sv
// ---------------------------------------------------------------------------
// sca_stim_engine_if
// Bundles the pin-side signals of the SCA stimulus engine.
//   Host serial port : sclk, sdi, shift_en, start_req (in), sdo (out)
//   Flip source      : flip_in (in)
//   DUT side         : dut_out (in), dut_in (out)
//   Status           : trig, busy, done, cap_cnt (out)
// Modports:
//   slave  - the engine (consumes pins, drives DUT inputs and status)
//   master - the board / bench side
// ---------------------------------------------------------------------------
interface sca_stim_engine_if #(
  parameter int NUM_INS  = 46,
  parameter int NUM_OUTS = 7,
  parameter int CNT_W    = 16
);
  logic                sclk;
  logic                sdi;
  logic                shift_en;
  logic                start_req;
  logic                flip_in;
  logic [NUM_OUTS-1:0] dut_out;
  logic [NUM_INS-1:0]  dut_in;
  logic                sdo;
  logic                trig;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    cap_cnt;

  modport slave (
    input  sclk, sdi, shift_en, start_req, flip_in, dut_out,
    output dut_in, sdo, trig, busy, done, cap_cnt
  );

  modport master (
    output sclk, sdi, shift_en, start_req, flip_in, dut_out,
    input  dut_in, sdo, trig, busy, done, cap_cnt
  );
endinterface

// File: rtl/sca_stim_engine.sv
// ---------------------------------------------------------------------------
// sca_stim_engine
// Drives the inputs of a locked DUT and captures its outputs for side-channel
// unlock experiments. A bit-banged serial port loads a configuration word
// {value, mask, mode[1:0], period} and reads back the captured outputs.
//
// Drive modes (a_mode):
//   0 static          : dut_in = value, one capture, back to IDLE
//   1 external flip   : masked bits follow flip_in combinationally, one capture
//   2 single toggle   : masked bits inverted until the capture, one capture
//   3 continuous      : masked bits invert on every capture until stopped
//
// Ports:
//   clk    - system clock, all control logic lives here
//   rst_n  - asynchronous active-low reset
//   bus    - sca_stim_engine_if.slave:
//            sclk/sdi/shift_en/start_req : asynchronous host pins
//            flip_in                     : asynchronous flip source
//            dut_out / dut_in            : DUT outputs / DUT inputs
//            sdo                         : serial readback
//            trig                        : scope trigger (phase while busy)
//            busy                        : run in progress
//            done                        : one-cycle pulse per capture
//            cap_cnt                     : captures since last start
// ---------------------------------------------------------------------------
module sca_stim_engine #(
  parameter int NUM_INS  = 46,
  parameter int NUM_OUTS = 7,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst_n,
  sca_stim_engine_if.slave bus
);

  localparam int CFG_W    = 2*NUM_INS + 2 + CNT_W;
  localparam int MODE_LSB = CNT_W;
  localparam int MASK_LSB = CNT_W + 2;
  localparam int VAL_LSB  = CNT_W + 2 + NUM_INS;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Synchroniser bit order: {start_req, shift_en, sdi, sclk}
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic                r_sclk_prev;
  logic                r_start_prev;

  logic [CFG_W-1:0]    r_cfg;
  logic [NUM_OUTS-1:0] r_outr;
  logic [NUM_INS-1:0]  r_a_val;
  logic [NUM_INS-1:0]  r_a_mask;
  logic [1:0]          r_a_mode;
  logic [CNT_W-1:0]    r_a_per;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_cap_cnt;
  logic                r_phase;
  logic                r_stop_pend;

  logic                w_sclk_fall;
  logic                w_start_rise;
  logic                w_sdi_s;
  logic                w_shift_en_s;
  logic                w_start;
  logic                w_capture;
  logic                w_run_end;
  logic                w_stop_set;
  logic                w_busy;
  logic [NUM_INS-1:0]  w_dut_in;

  // -------------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_sclk_prev  <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_sync1      <= {bus.start_req, bus.shift_en, bus.sdi, bus.sclk};
      r_sync2      <= r_sync1;
      r_sclk_prev  <= r_sync2[0];
      r_start_prev <= r_sync2[3];
    end
  end

  // Actions fire in the cycle where the second stage first differs from its
  // previous value. sdi and shift_en are used at the same synchroniser depth
  // as sclk so data set up together with the clock pin is seen together.
  assign w_sclk_fall  = r_sclk_prev & ~r_sync2[0];
  assign w_start_rise = r_sync2[3] & ~r_start_prev;
  assign w_sdi_s      = r_sync2[1];
  assign w_shift_en_s = r_sync2[2];

  // -------------------------------------------------------------------------
  // Run FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_run_end   = 1'b0;
    w_stop_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == r_a_per) begin
          w_capture = 1'b1;
          // Only continuous mode survives a capture, and only until stopped.
          if ((r_a_mode != 2'd3) || r_stop_pend) begin
            w_run_end   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        // A start rise during a continuous run requests a stop; in the
        // single-shot modes it is ignored.
        if (w_start_rise && (r_a_mode == 2'd3)) begin
          w_stop_set = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy = (r_state == S_RUN);

  // -------------------------------------------------------------------------
  // Configuration chain (shiftable in any state)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= '0;
    end else if (w_sclk_fall && !w_shift_en_s) begin
      r_cfg <= {r_cfg[CFG_W-2:0], w_sdi_s};
    end
  end

  // -------------------------------------------------------------------------
  // Output capture / readback chain; a capture beats a same-cycle shift
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outr <= '0;
    end else if (w_capture) begin
      r_outr <= bus.dut_out;
    end else if (w_sclk_fall && w_shift_en_s) begin
      r_outr <= {r_outr[NUM_OUTS-2:0], 1'b0};
    end
  end

  // -------------------------------------------------------------------------
  // Active run registers, period counter, phase and stop request
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_val     <= '0;
      r_a_mask    <= '0;
      r_a_mode    <= 2'd0;
      r_a_per     <= '0;
      r_cnt       <= '0;
      r_cap_cnt   <= '0;
      r_phase     <= 1'b0;
      r_stop_pend <= 1'b0;
    end else if (w_start) begin
      r_a_val     <= r_cfg[VAL_LSB +: NUM_INS];
      r_a_mask    <= r_cfg[MASK_LSB +: NUM_INS];
      r_a_mode    <= r_cfg[MODE_LSB +: 2];
      r_a_per     <= r_cfg[CNT_W-1:0];
      r_cnt       <= '0;
      r_cap_cnt   <= '0;
      // Toggle modes (2 and 3) start with the masked bits inverted.
      r_phase     <= r_cfg[MODE_LSB + 1];
      r_stop_pend <= 1'b0;
    end else if (w_busy) begin
      if (w_capture) begin
        r_cnt     <= '0;
        r_cap_cnt <= r_cap_cnt + 1'b1;
        if (w_run_end) begin
          r_phase <= 1'b0;
        end else if (r_a_mode == 2'd3) begin
          r_phase <= ~r_phase;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_run_end) begin
        r_stop_pend <= 1'b0;
      end else if (w_stop_set) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // DUT drive. The external flip path is deliberately combinational so the
  // edge timing of flip_in reaches the DUT without clk-domain jitter.
  // -------------------------------------------------------------------------
  always_comb begin
    w_dut_in = r_a_val;
    if (w_busy) begin
      if (r_a_mode == 2'd1) begin
        w_dut_in = (r_a_val & ~r_a_mask) | (r_a_mask & {NUM_INS{bus.flip_in}});
      end else begin
        w_dut_in = r_a_val ^ (r_a_mask & {NUM_INS{r_phase}});
      end
    end
  end

  assign bus.dut_in  = w_dut_in;
  assign bus.sdo     = w_shift_en_s ? r_outr[NUM_OUTS-1] : r_cfg[CFG_W-1];
  assign bus.trig    = r_phase & w_busy;
  assign bus.busy    = w_busy;
  assign bus.done    = w_capture;
  assign bus.cap_cnt = r_cap_cnt;

endmodule
